// File: rtl/id_hazard_ctrl_pkg.sv
// Shared constants, types and helpers for the decode-stage hazard scoreboard.
// The optional ID_HAZARD_FWD_EN macro is consumed by id_hazard_ctrl.
`ifndef RADDR_WIDTH
`define RADDR_WIDTH 5
`endif
`ifndef ZERO_REG
`define ZERO_REG 0
`endif
`ifndef HZ_MAX_INFLIGHT
`define HZ_MAX_INFLIGHT 4
`endif
`ifndef HZ_CNT_W
`define HZ_CNT_W 3
`endif
`ifndef STALL_ENABLE
`define STALL_ENABLE 1'b1
`endif
`ifndef STALL_DISABLE
`define STALL_DISABLE 1'b0
`endif

package id_hazard_ctrl_pkg;

  localparam int unsigned RADDR_W         = `RADDR_WIDTH;
  localparam int unsigned NUM_REGS        = 1 << RADDR_W;
  localparam int unsigned HZ_MAX_INFLIGHT = `HZ_MAX_INFLIGHT;
  localparam int unsigned HZ_CNT_W        = `HZ_CNT_W;

  localparam logic [RADDR_W-1:0] ZERO_REG = RADDR_W'(`ZERO_REG);
  localparam logic               STALL_EN  = `STALL_ENABLE;
  localparam logic               STALL_DIS = `STALL_DISABLE;

  // One source-operand read request from the decoder.
  typedef struct packed {
    logic               re;
    logic [RADDR_W-1:0] addr;
  } src_req_t;

  // A read can only hazard when enabled and not targeting the hard-wired zero register.
  function automatic logic src_tracked(input src_req_t s);
    return s.re & (s.addr != ZERO_REG);
  endfunction

endpackage

// File: rtl/id_hz_cnt.sv
// Single up/down occupancy counter with synchronous clear and a zero flag.
module id_hz_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  // Simultaneous inc and dec cancel; clear wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc & ~i_dec) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec & ~i_inc) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt    = r_cnt;
  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Issue-stage scoreboard: tracks pending register writes, stalls RAW hazards and
// throttles issue at the in-flight budget. Define ID_HAZARD_FWD_EN for same-cycle writeback bypass.
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_INFLIGHT = HZ_MAX_INFLIGHT,
  parameter int unsigned CNT_W        = HZ_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  input  logic               reg1_re_i,
  input  logic [RADDR_W-1:0] reg1_raddr_i,
  input  logic               reg2_re_i,
  input  logic [RADDR_W-1:0] reg2_raddr_i,
  input  logic               reg_we_i,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               wb_valid_i,
  input  logic [RADDR_W-1:0] wb_waddr_i,
  output logic               stall_o,
  output logic               issue_o,
  output logic [CNT_W-1:0]   inflight_o,
  output logic               err_o
);

  src_req_t         w_src1;
  src_req_t         w_src2;
  logic [CNT_W-1:0] w_pend [NUM_REGS];
  logic             w_zero [NUM_REGS];
  logic [CNT_W-1:0] w_tot;
  logic             w_tot_zero;
  logic             w_wb;
  logic             w_full;
  logic             w_byp1;
  logic             w_byp2;
  logic             w_hz1;
  logic             w_hz2;
  logic             w_stall_c;
  logic             w_issue_c;
  logic             w_alloc;
  logic             w_ret;
  logic             w_undf;
  logic             w_dec_ok;
  logic             r_err;

  assign w_src1 = '{re: reg1_re_i, addr: reg1_raddr_i};
  assign w_src2 = '{re: reg2_re_i, addr: reg2_raddr_i};

  // x0 has no counter; it always reads as idle.
  assign w_pend[0] = '0;
  assign w_zero[0] = 1'b1;

`ifdef ID_HAZARD_FWD_EN
  // Last outstanding write retiring this cycle can feed the consumer from the bypass path.
  assign w_byp1 = wb_valid_i & (wb_waddr_i == w_src1.addr) & (w_pend[w_src1.addr] == CNT_W'(1));
  assign w_byp2 = wb_valid_i & (wb_waddr_i == w_src2.addr) & (w_pend[w_src2.addr] == CNT_W'(1));
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign w_hz1 = src_tracked(w_src1) & (w_pend[w_src1.addr] != '0) & ~w_byp1;
  assign w_hz2 = src_tracked(w_src2) & (w_pend[w_src2.addr] != '0) & ~w_byp2;

  assign w_wb   = reg_we_i & (reg_waddr_i != ZERO_REG);
  assign w_full = (w_tot == CNT_W'(MAX_INFLIGHT)) & w_wb;

  assign w_stall_c = issue_valid_i & ~flush_i & (w_hz1 | w_hz2 | w_full);
  assign w_issue_c = issue_valid_i & ~flush_i & ~w_stall_c;
  assign w_alloc   = w_issue_c & w_wb;

  assign stall_o = w_stall_c ? STALL_EN : STALL_DIS;
  assign issue_o = w_issue_c;

  // Retire checks registered occupancy; a retire with nothing pending is a protocol error.
  assign w_ret    = wb_valid_i & ~flush_i & (wb_waddr_i != ZERO_REG);
  assign w_undf   = w_ret & (w_zero[wb_waddr_i] | w_tot_zero);
  assign w_dec_ok = w_ret & ~w_undf;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_pend
    logic w_inc;
    logic w_dec;

    assign w_inc = w_alloc  & (reg_waddr_i == RADDR_W'(g));
    assign w_dec = w_dec_ok & (wb_waddr_i  == RADDR_W'(g));

    id_hz_cnt #(
      .W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_inc    (w_inc),
      .i_dec    (w_dec),
      .i_clr    (flush_i),
      .o_cnt    (w_pend[g]),
      .o_zero_c (w_zero[g])
    );
  end

  id_hz_cnt #(
    .W (CNT_W)
  ) u_tot (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_inc    (w_alloc),
    .i_dec    (w_dec_ok),
    .i_clr    (flush_i),
    .o_cnt    (w_tot),
    .o_zero_c (w_tot_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (flush_i) begin
      r_err <= 1'b0;
    end else if (w_undf) begin
      r_err <= 1'b1;
    end
  end

  assign inflight_o = w_tot;
  assign err_o      = r_err;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: per-cycle comparison against a counting model
// plus literal expectations at the interesting points of each scenario.
module tb_id_hazard_ctrl;
  import id_hazard_ctrl_pkg::*;

  localparam int MAXI = 4;
  localparam int CW   = 3;
`ifdef ID_HAZARD_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               flush_i;
  logic               issue_valid_i;
  logic               reg1_re_i;
  logic [RADDR_W-1:0] reg1_raddr_i;
  logic               reg2_re_i;
  logic [RADDR_W-1:0] reg2_raddr_i;
  logic               reg_we_i;
  logic [RADDR_W-1:0] reg_waddr_i;
  logic               wb_valid_i;
  logic [RADDR_W-1:0] wb_waddr_i;
  logic               stall_o;
  logic               issue_o;
  logic [CW-1:0]      inflight_o;
  logic               err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pend [32];
  int m_tot = 0;
  int m_err = 0;

  id_hazard_ctrl #(
    .MAX_INFLIGHT (MAXI),
    .CNT_W        (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .issue_valid_i (issue_valid_i),
    .reg1_re_i     (reg1_re_i),
    .reg1_raddr_i  (reg1_raddr_i),
    .reg2_re_i     (reg2_re_i),
    .reg2_raddr_i  (reg2_raddr_i),
    .reg_we_i      (reg_we_i),
    .reg_waddr_i   (reg_waddr_i),
    .wb_valid_i    (wb_valid_i),
    .wb_waddr_i    (wb_waddr_i),
    .stall_o       (stall_o),
    .issue_o       (issue_o),
    .inflight_o    (inflight_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a read of r hazards while any write to r is outstanding (unless bypassed).
  function automatic int hz(input logic re, input logic [RADDR_W-1:0] a);
    int idx;
    idx = int'(a);
    if (!re || idx == 0 || m_pend[idx] == 0) return 0;
    if (FWD == 1 && wb_valid_i && int'(wb_waddr_i) == idx && m_pend[idx] == 1) return 0;
    return 1;
  endfunction

  function automatic int exp_stall();
    int full;
    full = (m_tot == MAXI && reg_we_i && int'(reg_waddr_i) != 0) ? 1 : 0;
    if (!issue_valid_i || flush_i) return 0;
    return (hz(reg1_re_i, reg1_raddr_i) + hz(reg2_re_i, reg2_raddr_i) + full) != 0 ? 1 : 0;
  endfunction

  function automatic int exp_issue();
    return (issue_valid_i && !flush_i && exp_stall() == 0) ? 1 : 0;
  endfunction

  function automatic int alloc_to(input int k);
    return (exp_issue() == 1 && reg_we_i && k != 0 && int'(reg_waddr_i) == k) ? 1 : 0;
  endfunction

  function automatic int retire_ok_to(input int k);
    return (wb_valid_i && k != 0 && int'(wb_waddr_i) == k && m_pend[k] > 0) ? 1 : 0;
  endfunction

  function automatic int retire_bad();
    return (wb_valid_i && int'(wb_waddr_i) != 0 && m_pend[int'(wb_waddr_i)] == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush_i) begin
      for (int k = 0; k < 32; k++) m_pend[k] <= 0;
      m_tot <= 0;
      m_err <= 0;
    end else begin
      for (int k = 1; k < 32; k++) m_pend[k] <= m_pend[k] + alloc_to(k) - retire_ok_to(k);
      m_tot <= m_tot + alloc_to(int'(reg_waddr_i)) - retire_ok_to(int'(wb_waddr_i));
      if (retire_bad() == 1) m_err <= 1;
    end
  end

  always @(negedge clk) begin
    chk("model_stall",    int'(stall_o),    exp_stall());
    chk("model_issue",    int'(issue_o),    exp_issue());
    chk("model_inflight", int'(inflight_o), m_tot);
    chk("model_err",      int'(err_o),      m_err);
  end

  task automatic drv(input int iv, input int r1, input int a1, input int r2, input int a2,
                     input int we, input int wa, input int wv, input int wba, input int fl);
    issue_valid_i = 1'(iv);
    reg1_re_i     = 1'(r1);
    reg1_raddr_i  = RADDR_W'(a1);
    reg2_re_i     = 1'(r2);
    reg2_raddr_i  = RADDR_W'(a2);
    reg_we_i      = 1'(we);
    reg_waddr_i   = RADDR_W'(wa);
    wb_valid_i    = 1'(wv);
    wb_waddr_i    = RADDR_W'(wba);
    flush_i       = 1'(fl);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    look();
    chk("reset_stall",    int'(stall_o),    0);
    chk("reset_issue",    int'(issue_o),    1);
    chk("reset_inflight", int'(inflight_o), 0);
    chk("reset_err",      int'(err_o),      0);
    rst_n = 1'b1;
    step();

    // RAW on x5
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); step();
    drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); look();
    chk("raw_x5_stall", int'(stall_o), 1);
    chk("raw_x5_issue", int'(issue_o), 0);
    step();
    drv(1, 1, 5, 0, 0, 0, 0, 1, 5, 0); look();
    chk("raw_x5_retire_cycle", int'(stall_o), FWD == 1 ? 0 : 1);
    step();
    drv(1, 1, 5, 0, 0, 0, 0, 0, 0, 0); look();
    chk("raw_x5_after_retire", int'(stall_o), 0);
    step();

    // structural limit
    for (int i = 1; i <= 4; i++) begin
      drv(1, 0, 0, 0, 0, 1, i, 0, 0, 0); step();
    end
    drv(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); look();
    chk("full_stall",    int'(stall_o),    1);
    chk("full_inflight", int'(inflight_o), 4);
    step();
    drv(1, 0, 0, 0, 0, 1, 6, 1, 1, 0); look();
    chk("full_retire_cycle_stall", int'(stall_o), 1);
    step();
    drv(1, 0, 0, 0, 0, 1, 6, 0, 0, 0); look();
    chk("full_freed_stall",    int'(stall_o),    0);
    chk("full_freed_inflight", int'(inflight_o), 3);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); look();
    chk("full_refill_inflight", int'(inflight_o), 4);
    for (int i = 2; i <= 4; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, i, 0); step();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 6, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); look();
    chk("drain_inflight", int'(inflight_o), 0);

    // x0 is never tracked
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 0, 1, 0, 1, 0, 0, 0, 0); look();
      chk("x0_stall", int'(stall_o), 0);
      step();
    end
    look();
    chk("x0_inflight", int'(inflight_o), 0);

    // WAW stacking on x7, read via source 2
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0); step();
    step();
    drv(1, 0, 0, 1, 7, 0, 0, 1, 7, 0); look();
    chk("waw_x7_first_retire", int'(stall_o), 1);
    step();
    drv(1, 0, 0, 1, 7, 0, 0, 0, 0, 0); look();
    chk("waw_x7_pend1",     int'(stall_o),    1);
    chk("waw_x7_inflight1", int'(inflight_o), 1);
    step();
    drv(1, 0, 0, 1, 7, 0, 0, 1, 7, 0); look();
    chk("waw_x7_last_retire", int'(stall_o), FWD == 1 ? 0 : 1);
    step();
    drv(1, 0, 0, 1, 7, 0, 0, 0, 0, 0); look();
    chk("waw_x7_clear", int'(stall_o), 0);
    step();

    // simultaneous issue and retire
    drv(1, 0, 0, 0, 0, 1, 8, 0, 0, 0); step();
    drv(1, 0, 0, 0, 0, 1, 8, 1, 8, 0); look();
    chk("same_reg_issue", int'(issue_o), 1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); look();
    chk("same_reg_inflight", int'(inflight_o), 1);
    drv(1, 0, 0, 0, 0, 1, 10, 1, 8, 0); step();
    drv(1, 1, 8, 1, 10, 0, 0, 0, 0, 0); look();
    chk("diff_reg_inflight", int'(inflight_o), 1);
    chk("diff_reg_stall",    int'(stall_o),    1);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 10, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); look();
    chk("x0_retire_no_err", int'(err_o),      0);
    chk("diff_reg_drained", int'(inflight_o), 0);

    // underflow error and flush
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0); step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); look();
    chk("underflow_err", int'(err_o), 1);
    step(); look();
    chk("underflow_sticky", int'(err_o), 1);
    drv(1, 0, 0, 0, 0, 1, 11, 0, 0, 0); step();
    drv(1, 1, 11, 0, 0, 0, 0, 0, 0, 0); look();
    chk("pre_flush_stall", int'(stall_o), 1);
    step();
    drv(1, 1, 11, 0, 0, 0, 0, 1, 11, 1); look();
    chk("flush_cycle_stall", int'(stall_o), 0);
    chk("flush_cycle_issue", int'(issue_o), 0);
    step();
    drv(1, 1, 11, 0, 0, 0, 0, 0, 0, 0); look();
    chk("post_flush_stall",    int'(stall_o),    0);
    chk("post_flush_issue",    int'(issue_o),    1);
    chk("post_flush_inflight", int'(inflight_o), 0);
    chk("post_flush_err",      int'(err_o),      0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
